// File: rtl/or8x4_dispatch_pkg.sv
// Shared sizing and state view for the OR-merged 8x4 lane dispatcher.
package or8x4_dispatch_pkg;
  localparam int WIDTH = 4;
  localparam int LANES = 8;

  typedef enum logic {IDLE = 1'b0, DELIVER = 1'b1} state_e;

  function automatic state_e state_of(input logic [LANES-1:0] pend);
    return (pend == '0) ? IDLE : DELIVER;
  endfunction
endpackage

// File: rtl/or8x4_dispatch_if.sv
// Input word handshake plus the per-lane valid/ready fan-out bus.
interface or8x4_dispatch_if;
  import or8x4_dispatch_pkg::*;

  logic [WIDTH-1:0]       I;
  logic [LANES-1:0]       I_MASK;
  logic                   I_VALID;
  logic                   I_READY;
  logic [LANES*WIDTH-1:0] O;
  logic [LANES-1:0]       O_VALID;
  logic [LANES-1:0]       O_READY;
  logic                   BUSY;
  logic [7:0]             DROP_CNT;

  modport slave (
    input  I, I_MASK, I_VALID, O_READY,
    output I_READY, O, O_VALID, BUSY, DROP_CNT
  );

  modport master (
    output I, I_MASK, I_VALID, O_READY,
    input  I_READY, O, O_VALID, BUSY, DROP_CNT
  );
endinterface

// File: rtl/or8x4_lane_gate.sv
// One destination lane: pending bit, retire-on-ready, and zero-gated data so
// idle lanes contribute nothing to the downstream OR merge.
module or8x4_lane_gate
  import or8x4_dispatch_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             sel_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);
  logic pend_q, pend_d;

  // A load overrides retirement: the new mask bit is taken as-is.
  always_comb begin
    pend_d = pend_q & ~ready_i;
    if (load_i) pend_d = sel_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pend_q <= 1'b0;
    else       pend_q <= pend_d;
  end

  assign valid_o = pend_q;
  assign data_o  = pend_q ? data_i : '0;
endmodule

// File: rtl/or8x4_dispatch.sv
// Accepts one word + lane mask and holds it until every selected lane has
// taken it; a new word may load on the cycle the last lane retires.
module or8x4_dispatch
  import or8x4_dispatch_pkg::*;
(
  input  logic             CLK,
  input  logic             ASYNCRESET,
  or8x4_dispatch_if.slave  bus
);
  logic [WIDTH-1:0]            data_q, data_d;
  logic [7:0]                  drop_q, drop_d;
  logic [LANES-1:0]            pend;
  logic [LANES-1:0][WIDTH-1:0] lane_data;
  logic                        done, accept;
  state_e                      state;

  assign state  = state_of(pend);
  assign done   = ((pend & ~bus.O_READY) == '0);
  assign accept = bus.I_VALID & bus.I_READY;

  assign bus.I_READY  = done & ~ASYNCRESET;
  assign bus.O        = lane_data;
  assign bus.O_VALID  = pend;
  assign bus.BUSY     = (state == DELIVER);
  assign bus.DROP_CNT = drop_q;

  always_comb begin
    data_d = data_q;
    drop_d = drop_q;
    if (accept) begin
      data_d = bus.I;
      if (bus.I_MASK == '0 && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      data_q <= '0;
      drop_q <= '0;
    end else begin
      data_q <= data_d;
      drop_q <= drop_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    or8x4_lane_gate u_lane (
      .clk_i   (CLK),
      .rst_i   (ASYNCRESET),
      .load_i  (accept),
      .sel_i   (bus.I_MASK[k]),
      .data_i  (data_q),
      .ready_i (bus.O_READY[k]),
      .data_o  (lane_data[k]),
      .valid_o (pend[k])
    );
  end

  // A stalled lane must keep seeing the same word until it retires.
  a_hold_stable: assert property (
    @(posedge CLK) disable iff (ASYNCRESET)
    (state == DELIVER && !done) |=> $stable(data_q)
  );
endmodule

// File: tb/tb_or8x4_dispatch.sv
// Scoreboarded bench for or8x4_dispatch: reference model of PEND/DATA/DROP_CNT
// plus directed scenarios for stalls, back-to-back, drops and async reset.
module tb_or8x4_dispatch;
  import or8x4_dispatch_pkg::*;

  logic CLK = 1'b0;
  logic ASYNCRESET = 1'b0;
  or8x4_dispatch_if bus();

  or8x4_dispatch dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .bus        (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;

  logic [7:0]  m_pend = '0;
  logic [7:0]  m_drop = '0;
  logic [3:0]  m_data = '0;
  logic        m_new  = 1'b0;
  logic [11:0] sb_q[$];

  wire m_ready = ((m_pend & ~bus.O_READY) == 8'h00) && !ASYNCRESET;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_o();
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) if (m_pend[k]) r[k*4 +: 4] = m_data;
    return r;
  endfunction

  // Reference model, stepped on the same edges as the DUT.
  always @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      m_pend <= '0;
      m_drop <= '0;
      m_data <= '0;
      m_new  <= 1'b0;
    end else if (bus.I_VALID && m_ready) begin
      m_data  <= bus.I;
      m_pend  <= bus.I_MASK;
      acc_cnt <= acc_cnt + 1;
      m_new   <= (bus.I_MASK != 8'h00);
      if (bus.I_MASK == 8'h00) begin
        if (m_drop != 8'hFF) m_drop <= m_drop + 8'd1;
      end else begin
        sb_q.push_back({bus.I, bus.I_MASK});
      end
    end else begin
      m_pend <= m_pend & ~bus.O_READY;
      m_new  <= 1'b0;
    end
  end

  // Per-cycle compare away from the active edge; scoreboard pops on fresh words.
  always @(negedge CLK) begin
    logic [11:0] ent;
    logic [3:0]  orn;
    chk("i_ready", 32'(bus.I_READY), 32'(m_ready));
    chk("o_valid", 32'(bus.O_VALID), 32'(m_pend));
    chk("o_data",  bus.O, exp_o());
    chk("busy",    32'(bus.BUSY), 32'(m_pend != 8'h00));
    chk("drop",    32'(bus.DROP_CNT), 32'(m_drop));
    if (m_new) begin
      if (sb_q.size() == 0) begin
        chk("sb_under", 32'(sb_q.size()), 32'd1);
      end else begin
        ent = sb_q.pop_front();
        orn = '0;
        for (int k = 0; k < 8; k++) orn |= bus.O[k*4 +: 4];
        chk("sb_word", 32'(orn), 32'(ent[11:8]));
        chk("sb_mask", 32'(bus.O_VALID), 32'(ent[7:0]));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int acc0;
    bus.I = '0; bus.I_MASK = '0; bus.I_VALID = 1'b0; bus.O_READY = '0;
    #1 ASYNCRESET = 1'b1;

    // Reset held: everything quiet.
    repeat (2) @(negedge CLK);
    chk("rst_ready", 32'(bus.I_READY), 32'd0);
    chk("rst_o",     bus.O, 32'h0);
    chk("rst_valid", 32'(bus.O_VALID), 32'd0);
    chk("rst_busy",  32'(bus.BUSY), 32'd0);
    step();
    ASYNCRESET = 1'b0;
    @(negedge CLK);
    chk("rel_ready", 32'(bus.I_READY), 32'd1);
    chk("rel_busy",  32'(bus.BUSY), 32'd0);
    chk("rel_o",     bus.O, 32'h0);

    // Single lane.
    step();
    bus.I = 4'hA; bus.I_MASK = 8'h04; bus.I_VALID = 1'b1; bus.O_READY = 8'hFF;
    step();
    bus.I_VALID = 1'b0; bus.I = 4'h3; bus.I_MASK = 8'hFF;
    @(negedge CLK);
    chk("one_o",     bus.O, 32'h0000_0A00);
    chk("one_valid", 32'(bus.O_VALID), 32'h04);
    step();
    @(negedge CLK);
    chk("one_clear", 32'(bus.O_VALID), 32'h00);

    // Broadcast with lane 7 stalled for three cycles.
    step();
    bus.I = 4'h5; bus.I_MASK = 8'hFF; bus.I_VALID = 1'b1; bus.O_READY = 8'h7F;
    step();
    bus.I_VALID = 1'b0; bus.I = 4'hE; bus.I_MASK = 8'h01;
    @(negedge CLK);
    chk("bc_all", 32'(bus.O_VALID), 32'hFF);
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge CLK);
      chk("bc_valid", 32'(bus.O_VALID), 32'h80);
      chk("bc_ready", 32'(bus.I_READY), 32'd0);
      chk("bc_o",     bus.O, 32'h5000_0000);
    end
    bus.O_READY = 8'hFF;
    #1;
    chk("bc_release", 32'(bus.I_READY), 32'd1);

    // Back-to-back one-hot words, all lanes ready.
    step();
    acc0 = acc_cnt;
    for (int i = 0; i < 16; i++) begin
      bus.I = 4'(15 - i); bus.I_MASK = 8'(1 << (i % 8)); bus.I_VALID = 1'b1;
      step();
    end
    bus.I_VALID = 1'b0;
    @(negedge CLK);
    chk("b2b_count", 32'(acc_cnt - acc0), 32'd16);
    step();

    // Zero-mask drops saturate the counter.
    bus.O_READY = 8'h00; bus.I_MASK = 8'h00; bus.I_VALID = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.I = 4'(i);
      step();
    end
    bus.I_VALID = 1'b0;
    @(negedge CLK);
    chk("drop_sat",   32'(bus.DROP_CNT), 32'hFF);
    chk("drop_valid", 32'(bus.O_VALID), 32'h00);
    chk("drop_busy",  32'(bus.BUSY), 32'd0);

    // Reset in the middle of a delivery, no clock edge needed.
    step();
    bus.I = 4'hC; bus.I_MASK = 8'h0F; bus.I_VALID = 1'b1;
    step();
    bus.I_VALID = 1'b0;
    @(negedge CLK);
    chk("mid_valid", 32'(bus.O_VALID), 32'h0F);
    #2 ASYNCRESET = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.O_VALID), 32'h00);
    chk("mid_rst_o",     bus.O, 32'h0);
    chk("mid_rst_busy",  32'(bus.BUSY), 32'd0);
    chk("mid_rst_ready", 32'(bus.I_READY), 32'd0);
    chk("mid_rst_drop",  32'(bus.DROP_CNT), 32'h00);
    step();
    ASYNCRESET = 1'b0;
    bus.O_READY = 8'hFF;
    repeat (3) begin
      step();
      @(negedge CLK);
      chk("post_rst_idle", 32'(bus.O_VALID), 32'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
